// File: rtl/cs_resolver.sv
// cs_resolver -- resolves a carry-save pair (S, C) into R = S + 2*C with a
// chunk-serial carry-propagate adder: CHUNK bits of the result are produced
// per cycle, so NCHUNK = ceil((WIDTH+1)/CHUNK) cycles per result.
//
// Optional accumulator: define CS_RESOLVE_ACC_EN to add ACC_W, acc_clr and
// acc_out (running sum of every result handed to the consumer).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   S/C pair presented
//   in_ready   out  block is idle and can accept a pair
//   sum_in     in   S vector [WIDTH-1:0]
//   carry_in   in   C vector [WIDTH-1:0], bit i has weight 2^(i+1)
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_data   out  resolved R [WIDTH+1:0]
//   busy       out  high while resolving or holding a result
//   acc_clr    in   (CS_RESOLVE_ACC_EN) synchronous accumulator clear
//   acc_out    out  (CS_RESOLVE_ACC_EN) accumulated results [ACC_W-1:0]
//
// state  | meaning
// IDLE   | waiting for an input handshake
// BUSY   | adding chunk k of the operands each cycle
// DONE   | result on out_data, waiting for out_ready

module cs_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
`ifdef CS_RESOLVE_ACC_EN
  , parameter int ACC_W = 24
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_data,
  output logic             busy
`ifdef CS_RESOLVE_ACC_EN
  , input  logic             acc_clr
  , output logic [ACC_W-1:0] acc_out
`endif
);

  localparam int NCHUNK = (WIDTH + 1 + CHUNK - 1) / CHUNK;
  localparam int W1     = WIDTH + 1;
  localparam int W2     = WIDTH + 2;
  localparam int SHW    = $clog2(W2) + 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         state_q;
  logic [W1-1:0]  a_q, b_q;
  logic           carry_q;
  logic [KW-1:0]  k_q;
  logic [W2-1:0]  res_q;

  logic [SHW-1:0] shamt;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0] csum;
  logic [W1-1:0]  mask;
  logic [W2-1:0]  sum_sh;
  logic [W1-1:0]  res_lo_d;

  // Shifting the operands right by k*CHUNK zero-fills above WIDTH, which
  // gives the padding of the last chunk for free.
  always_comb begin
    shamt    = SHW'(k_q) * SHW'(CHUNK);
    a_ch     = CHUNK'(a_q >> shamt);
    b_ch     = CHUNK'(b_q >> shamt);
    csum     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    mask     = W1'({CHUNK{1'b1}}) << shamt;
    sum_sh   = W2'(csum) << shamt;
    res_lo_d = (res_q[W1-1:0] & ~mask) | (sum_sh[W1-1:0] & mask);
  end

  // Bit WIDTH+1 of the last chunk's shifted sum is the carry out of bit
  // WIDTH, whether it lands in a padded sum bit or in the chunk carry-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= {1'b0, sum_in};
            b_q     <= {carry_in, 1'b0};
            carry_q <= 1'b0;
            k_q     <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_q[W1-1:0] <= res_lo_d;
          carry_q       <= csum[CHUNK];
          if (k_q == K_LAST) begin
            res_q[W2-1] <= sum_sh[W2-1];
            state_q     <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = res_q;

`ifdef CS_RESOLVE_ACC_EN
  logic [ACC_W-1:0] acc_q;
  logic             out_hs;

  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= out_hs ? ACC_W'(res_q) : '0;
    end else if (out_hs) begin
      acc_q <= acc_q + ACC_W'(res_q);
    end
  end

  assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_cs_resolver.sv
module tb_cs_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ordy, acc_clr;
  logic [15:0] s, c;
  int          sel;
  int          total = 0;
  int          bad = 0;
  int          tcyc = 0;

  logic        iv0, ir0, ov0, bz0;
  logic        iv1, ir1, ov1, bz1;
  logic        iv17, ir17, ov17, bz17;
  logic [17:0] od0, od1, od17;
`ifdef CS_RESOLVE_ACC_EN
  logic [23:0] acc0, acc1, acc17;
`endif

  logic        ov_sel, ir_sel;
  logic [17:0] od_sel;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  assign iv0  = iv & (sel == 0);
  assign iv1  = iv & (sel == 1);
  assign iv17 = iv & (sel == 2);
  assign ov_sel = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov17;
  assign ir_sel = (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir17;
  assign od_sel = (sel == 0) ? od0 : (sel == 1) ? od1 : od17;

  cs_resolver #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .sum_in(s), .carry_in(c), .out_valid(ov0), .out_ready(ordy),
    .out_data(od0), .busy(bz0)
`ifdef CS_RESOLVE_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc0)
`endif
  );

  cs_resolver #(.WIDTH(16), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .sum_in(s), .carry_in(c), .out_valid(ov1), .out_ready(ordy),
    .out_data(od1), .busy(bz1)
`ifdef CS_RESOLVE_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc1)
`endif
  );

  cs_resolver #(.WIDTH(16), .CHUNK(17)) u17 (
    .clk(clk), .rst(rst), .in_valid(iv17), .in_ready(ir17),
    .sum_in(s), .carry_in(c), .out_valid(ov17), .out_ready(ordy),
    .out_data(od17), .busy(bz17)
`ifdef CS_RESOLVE_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc17)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the selected DUT idle; returns at the negedge
  // where out_valid is first seen, with the cycle count since the accept edge.
  task automatic run(input logic [15:0] sv, input logic [15:0] cv,
                     output int lat, output logic ir_low);
    ordy = 1'b0;
    s = sv; c = cv; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    lat = 0;
    ir_low = 1'b1;
    while (!ov_sel && lat < 60) begin
      ir_low &= ~ir_sel;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  task automatic btb(input int period);
    logic [15:0] ps, pc;
    logic [17:0] exp;
    int          t_prev, cnt;
    t_prev = 0;
    ordy = 1'b1;
    ps = 16'($urandom); pc = 16'($urandom);
    s = ps; c = pc; iv = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cnt = 0;
      while (!ov_sel && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      chk("btb_valid", {31'd0, ov_sel}, 32'd1);
      exp = {2'b00, ps} + {1'b0, pc, 1'b0};
      chk("btb_data", {14'd0, od_sel}, {14'd0, exp});
      if (j > 0) chk("btb_spacing", tcyc - t_prev, period);
      t_prev = tcyc;
      ps = 16'($urandom); pc = 16'($urandom);
      s = ps; c = pc;
      @(negedge clk);
    end
    iv = 1'b0;
    ordy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic irl, stable, hold, saw_ov;

    rst = 1'b1; iv = 1'b0; ordy = 1'b0; acc_clr = 1'b0;
    s = '0; c = '0; sel = 0;
    #3;
    chk("rst_in_ready", {31'd0, ir0}, 32'd1);
    chk("rst_out_valid", {31'd0, ov0}, 32'd0);
    chk("rst_out_data", {14'd0, od0}, 32'd0);
    chk("rst_busy", {31'd0, bz0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic resolve
    run(16'h0005, 16'h0003, lat, irl);
    chk("basic_latency", lat, 5);
    chk("basic_in_ready_low", {31'd0, irl}, 32'd1);
    chk("basic_data", {14'd0, od0}, 32'h0000B);
    chk("basic_busy_done", {31'd0, bz0}, 32'd1);

    // backpressure in DONE
    stable = 1'b1; hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv = ~iv; s = 16'($urandom); c = 16'($urandom);
      @(negedge clk);
      if (od0 !== 18'h0000B) stable = 1'b0;
      if (ir0 !== 1'b0 || ov0 !== 1'b1) hold = 1'b0;
    end
    chk("bp_data_stable", {31'd0, stable}, 32'd1);
    chk("bp_hold_done", {31'd0, hold}, 32'd1);
    iv = 1'b0;
    release_out();
    chk("bp_release_ready", {31'd0, ir0}, 32'd1);
    chk("bp_release_valid", {31'd0, ov0}, 32'd0);
    chk("idle_keeps_data", {14'd0, od0}, 32'h0000B);

    // maximum value
    run(16'hFFFF, 16'hFFFF, lat, irl);
    chk("max_latency", lat, 5);
    chk("max_data", {14'd0, od0}, 32'h2FFFD);
    release_out();
`ifdef CS_RESOLVE_ACC_EN
    chk("acc_sum", {8'd0, acc0}, 32'h030008);
`endif

    // accumulator clear coinciding with a handshake
    run(16'h1234, 16'h0001, lat, irl);
    chk("pre_clr_data", {14'd0, od0}, 32'h01236);
    acc_clr = 1'b1;
    release_out();
    acc_clr = 1'b0;
`ifdef CS_RESOLVE_ACC_EN
    chk("acc_clr_hs", {8'd0, acc0}, 32'h001236);
`endif

    // reset during chunk 2
    s = 16'hAAAA; c = 16'h5555; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, ir0}, 32'd1);
    chk("mid_rst_busy", {31'd0, bz0}, 32'd0);
    chk("mid_rst_data", {14'd0, od0}, 32'd0);
    saw_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov0 !== 1'b0) saw_ov = 1'b1;
    end
    chk("mid_rst_no_valid", {31'd0, saw_ov}, 32'd0);
    run(16'h1234, 16'h0001, lat, irl);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_data", {14'd0, od0}, 32'h01236);
    release_out();
`ifdef CS_RESOLVE_ACC_EN
    chk("acc_after_rst", {8'd0, acc0}, 32'h001236);
`endif

    // back-to-back, CHUNK=4
    btb(7);

    // CHUNK=1
    sel = 1;
    run(16'hFFFF, 16'hFFFF, lat, irl);
    chk("c1_latency", lat, 17);
    chk("c1_data", {14'd0, od1}, 32'h2FFFD);
    release_out();
    btb(19);

    // CHUNK=17
    sel = 2;
    run(16'h0005, 16'h0003, lat, irl);
    chk("c17_latency", lat, 1);
    chk("c17_data", {14'd0, od17}, 32'h0000B);
    release_out();
    btb(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
